// File: rtl/mul_issue_ctrl.sv
// Sequencer between the execute stage and the shared iterative 32x32 multiplier for RV32M
// MUL/MULH/MULHSU/MULHU, with a one-entry product cache so a high/low pair multiplies once.
module mul_issue_ctrl #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [31:0] i_req_rs1,
    input  logic [31:0] i_req_rs2,
    input  logic        i_flush,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_mul_start,
    output logic        o_mul_a_signed,
    output logic        o_mul_b_signed,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic        i_mul_ready,
    input  logic        i_mul_done,
    input  logic [63:0] i_mul_product,
    output logic        o_busy
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_reg, state_next;
    logic [1:0]  op_reg;
    logic [31:0] rs1_reg, rs2_reg;
    logic        a_signed_reg, b_signed_reg;
    logic        discard_reg;

    logic        cache_valid_reg;
    logic [31:0] cache_a_reg, cache_b_reg;
    logic        cache_a_signed_reg, cache_b_signed_reg;
    logic [63:0] cache_prod_reg;

    logic        req_a_signed, req_b_signed;
    logic        accept, hit;

    always_comb begin
        req_a_signed = (i_req_op == OP_MULH) || (i_req_op == OP_MULHSU);
        req_b_signed = (i_req_op == OP_MULH);
    end

    assign o_req_ready = (state_reg == ST_IDLE) && i_rst_n;
    assign accept      = i_req_valid && o_req_ready && !i_flush;

    // MUL ignores signedness: the low product half is the same for every pairing.
    assign hit = CACHE_EN && cache_valid_reg
              && (i_req_rs1 == cache_a_reg) && (i_req_rs2 == cache_b_reg)
              && ((i_req_op == OP_MUL)
                  || ((req_a_signed == cache_a_signed_reg) && (req_b_signed == cache_b_signed_reg)));

    always_comb begin
        state_next  = state_reg;
        o_mul_start = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = hit ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_flush) begin
                    state_next = ST_IDLE;
                end else if (i_mul_ready) begin
                    o_mul_start = 1'b1;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mul_done) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_next = (discard_reg || i_flush) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (i_flush || i_rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg          <= ST_IDLE;
            op_reg             <= 2'b00;
            rs1_reg            <= 32'd0;
            rs2_reg            <= 32'd0;
            a_signed_reg       <= 1'b0;
            b_signed_reg       <= 1'b0;
            discard_reg        <= 1'b0;
            cache_valid_reg    <= 1'b0;
            cache_a_reg        <= 32'd0;
            cache_b_reg        <= 32'd0;
            cache_a_signed_reg <= 1'b0;
            cache_b_signed_reg <= 1'b0;
            cache_prod_reg     <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg       <= i_req_op;
                rs1_reg      <= i_req_rs1;
                rs2_reg      <= i_req_rs2;
                a_signed_reg <= req_a_signed;
                b_signed_reg <= req_b_signed;
            end
            // A kill during the multiply only suppresses the response; the product is still kept.
            if (state_reg == ST_WAIT && i_flush) begin
                discard_reg <= 1'b1;
            end else if (state_reg == ST_CAPTURE) begin
                discard_reg <= 1'b0;
            end
            if (state_reg == ST_CAPTURE) begin
                cache_valid_reg    <= 1'b1;
                cache_a_reg        <= rs1_reg;
                cache_b_reg        <= rs2_reg;
                cache_a_signed_reg <= a_signed_reg;
                cache_b_signed_reg <= b_signed_reg;
                cache_prod_reg     <= i_mul_product;
            end
        end
    end

    assign o_rsp_valid    = (state_reg == ST_RESP);
    assign o_rsp_data     = !o_rsp_valid ? 32'd0
                          : (op_reg == OP_MUL) ? cache_prod_reg[31:0] : cache_prod_reg[63:32];
    assign o_mul_a        = rs1_reg;
    assign o_mul_b        = rs2_reg;
    assign o_mul_a_signed = a_signed_reg;
    assign o_mul_b_signed = b_signed_reg;
    assign o_busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl: two instances (cache on / cache off), a behavioural
// iterative multiplier per instance, and an arithmetic reference for every RV32M result.
module tb_mul_issue_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, flush, rsp_ready, sel;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2;

    logic [1:0]        req_ready_v, rsp_valid_v, start_v, as_v, bs_v, mready_v, mdone_v, busy_v, mbusy_v;
    logic [1:0][31:0]  rsp_data_v, mul_a_v, mul_b_v;
    logic [1:0][63:0]  prod_v;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          txn = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    logic        c_valid, c_as, c_bs;
    logic [31:0] c_a, c_b;

    function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic as, input logic bs);
        logic [63:0] ea, eb;
        ea = as ? {{32{a[31]}}, a} : {32'd0, a};
        eb = bs ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd1:    p = full_prod(a, b, 1'b1, 1'b1);
            2'd2:    p = full_prod(a, b, 1'b1, 1'b0);
            default: p = full_prod(a, b, 1'b0, 1'b0);
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic        is_sel, mbusy, mdone, mas, mbs;
            logic [1:0]  mcnt;
            logic [31:0] ma, mb;
            logic [63:0] mprod;
            assign is_sel = (gi == 0) ? ~sel : sel;

            mul_issue_ctrl #(.CACHE_EN(gi == 0)) dut (
                .i_clk          (clk),
                .i_rst_n        (rst_n),
                .i_req_valid    (req_valid & is_sel),
                .o_req_ready    (req_ready_v[gi]),
                .i_req_op       (req_op),
                .i_req_rs1      (req_rs1),
                .i_req_rs2      (req_rs2),
                .i_flush        (flush & is_sel),
                .o_rsp_valid    (rsp_valid_v[gi]),
                .i_rsp_ready    (rsp_ready & is_sel),
                .o_rsp_data     (rsp_data_v[gi]),
                .o_mul_start    (start_v[gi]),
                .o_mul_a_signed (as_v[gi]),
                .o_mul_b_signed (bs_v[gi]),
                .o_mul_a        (mul_a_v[gi]),
                .o_mul_b        (mul_b_v[gi]),
                .i_mul_ready    (mready_v[gi]),
                .i_mul_done     (mdone_v[gi]),
                .i_mul_product  (prod_v[gi]),
                .o_busy         (busy_v[gi])
            );

            assign mready_v[gi] = ~mbusy;
            assign mdone_v[gi]  = mdone;
            assign prod_v[gi]   = mprod;
            assign mbusy_v[gi]  = mbusy;

            // Iterative multiplier: random 1..4 cycle run, one done cycle, product valid after it.
            always @(posedge clk) begin
                if (!rst_n) begin
                    mbusy <= 1'b0;
                    mdone <= 1'b0;
                    mcnt  <= 2'd0;
                    mprod <= 64'd0;
                end else begin
                    mdone <= 1'b0;
                    if (mdone) begin
                        mprod <= full_prod(ma, mb, mas, mbs);
                        mbusy <= 1'b0;
                    end else if (mbusy) begin
                        if (mcnt == 2'd0) mdone <= 1'b1;
                        else mcnt <= mcnt - 2'd1;
                    end else if (start_v[gi]) begin
                        mbusy <= 1'b1;
                        mcnt  <= 2'($urandom_range(0, 3));
                        ma    <= mul_a_v[gi];
                        mb    <= mul_b_v[gi];
                        mas   <= as_v[gi];
                        mbs   <= bs_v[gi];
                    end
                end
            end
        end
    endgenerate

    logic        req_ready_m, rsp_valid_m, start_m, as_m, bs_m, mdone_m, busy_m, mbusy_m;
    logic [31:0] rsp_data_m, mul_a_m, mul_b_m;
    assign req_ready_m = req_ready_v[sel];
    assign rsp_valid_m = rsp_valid_v[sel];
    assign start_m     = start_v[sel];
    assign as_m        = as_v[sel];
    assign bs_m        = bs_v[sel];
    assign mdone_m     = mdone_v[sel];
    assign busy_m      = busy_v[sel];
    assign mbusy_m     = mbusy_v[sel];
    assign rsp_data_m  = rsp_data_v[sel];
    assign mul_a_m     = mul_a_v[sel];
    assign mul_b_m     = mul_b_v[sel];

    always @(posedge clk) begin
        if (rst_n && start_m) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response beat is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid_m && rsp_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rsp_data", {32'd0, rsp_data_m}, {32'd0, mon_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 normal, 1 flush one cycle in WAIT, 2 flush with the response beat, 3 reset in WAIT
    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode_in, input int stall);
        logic        hit, eas, ebs, seen, flushed, stable_ok, done_loop;
        logic [31:0] expv, d0;
        int          mode, t, dcyc, rcyc, fcyc, held, s0;
        eas  = (op == 2'd1) || (op == 2'd2);
        ebs  = (op == 2'd1);
        hit  = !sel && c_valid && (a == c_a) && (b == c_b) && (op == 2'd0 || (eas == c_as && ebs == c_bs));
        mode = (hit && (mode_in == 1 || mode_in == 3)) ? 0 : mode_in;
        expv = ref_result(op, a, b);
        t = 0;
        while (!req_ready_m && t < 50) begin
            step();
            t++;
        end
        chk("req_ready_idle", {63'd0, req_ready_m}, 64'd1);
        s0 = start_cnt;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
        step();
        req_valid = 1'b0;
        if (mode == 0) exp_q.push_back(expv);
        if (hit) chk("hit_latency", {63'd0, rsp_valid_m}, 64'd1);
        else     chk("miss_start", {63'd0, start_m}, 64'd1);
        dcyc = -1; rcyc = -1; fcyc = -1; held = 0;
        seen = 1'b0; flushed = 1'b0; stable_ok = 1'b1; done_loop = 1'b0;
        for (t = 0; t < 200 && !done_loop; t++) begin
            flush = 1'b0;
            rsp_ready = 1'b0;
            if (req_ready_m) begin
                done_loop = 1'b1;
                fcyc = t;
            end else begin
                if (mdone_m && dcyc < 0) dcyc = t;
                if (mode == 3 && mbusy_m) begin
                    rst_n = 1'b0;
                    step();
                    chk("reset_outputs", {req_ready_m, rsp_valid_m, rsp_data_m, start_m, mul_a_m[7:0],
                                          mul_b_m[7:0], as_m, bs_m, busy_m}, 64'd0);
                    chk("reset_mul_ab", {mul_a_m, mul_b_m}, 64'd0);
                    rst_n = 1'b1;
                    exp_q.delete();
                    c_valid = 1'b0;
                    done_loop = 1'b1;
                end else begin
                    if (mode == 1 && !flushed && mbusy_m) begin
                        flush = 1'b1;
                        flushed = 1'b1;
                    end
                    if (rsp_valid_m) begin
                        if (!seen) begin
                            seen = 1'b1;
                            rcyc = t;
                            d0 = rsp_data_m;
                        end else if (rsp_data_m !== d0) begin
                            stable_ok = 1'b0;
                        end
                        if (held < stall) held++;
                        else begin
                            rsp_ready = 1'b1;
                            if (mode == 2) flush = 1'b1;
                        end
                    end
                    step();
                end
            end
        end
        flush = 1'b0;
        rsp_ready = 1'b0;
        chk("timeout", {63'd0, done_loop}, 64'd1);
        chk("start_count", 64'(start_cnt - s0), hit ? 64'd0 : 64'd1);
        if (mode != 3) begin
            chk("rsp_seen", {63'd0, seen}, (mode == 1) ? 64'd0 : 64'd1);
            if (seen && stall > 0) chk("rsp_stable", {63'd0, stable_ok}, 64'd1);
            if (!hit && mode != 1) chk("miss_latency", 64'(rcyc - dcyc), 64'd2);
            if (!hit && mode == 1) chk("busy_until_capture", 64'(fcyc - dcyc), 64'd2);
            chk("mul_ab", {mul_a_m, mul_b_m}, {a, b});
            chk("mul_signed", {62'd0, as_m, bs_m}, {62'd0, eas, ebs});
            if (!hit && !sel) begin
                c_valid = 1'b1; c_a = a; c_b = b; c_as = eas; c_bs = ebs;
            end
        end
        $display("txn %0d dut=%0d op=%0d a=%h b=%h mode=%0d stall=%0d hit=%0d exp=%h",
                 txn, sel, op, a, b, mode, stall, hit, expv);
        txn++;
    endtask

    task automatic rand_reqs(input int n);
        logic [31:0] pool [6];
        logic [31:0] a, b;
        int r, m;
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'd7;
        pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h8000_0000; pool[5] = 32'h7FFF_FFFF;
        a = 32'd3; b = 32'd5;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
                b = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            end
            r = $urandom_range(0, 9);
            m = (r < 7) ? 0 : (r < 9) ? 1 : 2;
            do_req(2'($urandom_range(0, 3)), a, b, m, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
        req_op = 2'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; c_valid = 1'b0;
        c_a = 32'd0; c_b = 32'd0; c_as = 1'b0; c_bs = 1'b0;
        repeat (3) step();
        chk("rst_ready", {63'd0, req_ready_m}, 64'd0);
        chk("rst_ctrl", {60'd0, rsp_valid_m, start_m, as_m | bs_m, busy_m}, 64'd0);
        chk("rst_data", {32'd0, rsp_data_m}, 64'd0);
        chk("rst_mul_ab", {mul_a_m, mul_b_m}, 64'd0);
        rst_n = 1'b1;
        step();

        do_req(2'd0, 32'd7, 32'd6, 0, 0);
        do_req(2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
        do_req(2'd3, 32'hFFFF_FFFF, 32'd2, 0, 0);
        do_req(2'd3, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_req(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_req(2'd2, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_req(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
        do_req(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        do_req(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 5);
        do_req(2'd2, 32'd5, 32'hFFFF_FFF9, 2, 1);
        do_req(2'd2, 32'd5, 32'hFFFF_FFF9, 0, 0);
        rand_reqs(60);

        do_req(2'd1, 32'd11, 32'd22, 0, 0);
        do_req(2'd1, 32'd33, 32'd44, 3, 0);
        do_req(2'd1, 32'd33, 32'd44, 0, 0);

        sel = 1'b1;
        step();
        do_req(2'd2, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_req(2'd2, 32'hFFFF_FFFE, 32'd3, 0, 0);
        rand_reqs(10);

        repeat (3) step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
